// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit timing
// used by both the receive and transmit paths, so the two ends cannot drift.
package uart_pkg;

  // 115200 baud at a 100 MHz PLL clock
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int DATA_BITS_DEF    = 8;
  localparam int SYNC_STAGES_DEF  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    RECOVER = 3'd4
  } rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Reset value is a parameter so an idle-high line does not look like a
// falling edge when reset releases.
module sync_ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  // Shift the raw input through DEPTH flops; chain[0] is the first stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {DEPTH{RESET_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: synchronises the pin, finds the start bit, samples each
// bit at mid-bit and offers the byte on a valid/ready stream.
//
// Stream handshake: data_valid is raised with data_out holding a byte; a
// transfer happens at any rising edge where data_valid && data_ready. While
// data_valid is high and data_ready is low, data_out does not change. A good
// frame arriving while the holding register is still full (and not being
// drained that same cycle) is dropped and reported by a one-cycle overrun.
//
// CLKS_PER_BIT must be >= 4, DATA_BITS in 5..8, SYNC_STAGES >= 2.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic                 clk_100p0,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  // Start bit is checked half a bit after detection, then every full bit
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  // FSM state kept as a named signal so checkers can bind to it
  rx_state_t            state;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;

  sync_ff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk_100p0),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // Receive FSM, bit timing, holding register and status pulses
  always_ff @(posedge clk_100p0 or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;

      // Consumer drain; a reload at good-stop below overrides this
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
            busy     <= 1'b1;
          end
        end

        START: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (!rx_s) begin
            baud_cnt <= BIT_LOAD;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            // Line went back high before mid start bit: a glitch
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        DATA: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else begin
            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
            baud_cnt  <= BIT_LOAD;
            if (bit_idx == LAST_IDX) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + IW'(1);
            end
          end
        end

        STOP: begin
          if (baud_cnt != '0) begin
            baud_cnt <= baud_cnt - CW'(1);
          end else if (rx_s) begin
            // Back to IDLE at mid stop bit so an early next start is seen
            state <= IDLE;
            busy  <= 1'b0;
            if (!data_valid || data_ready) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            framing_err <= 1'b1;
            state       <= RECOVER;
          end
        end

        RECOVER: begin
          // A held-low (break) line yields a single framing error
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- 8N1 UART receiver for the pin-side serial input (the ICE_27-class pin), operating in the PLL clock domain.
- Synchronises the asynchronous line and detects the start bit. Samples each bit at mid-bit and presents the received byte on a valid/ready stream toward the PipelineC core.
- Counterpart of the existing UART transmit path; both share bit timing.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit (115200 baud at 100 MHz); must be >= 4.
- DATA_BITS, 8, data bits per frame, LSB first, 5..8.
- SYNC_STAGES, 2, metastability flops on rx_in, >= 2.

Ports:
- clk_100p0  in  1  PLL clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_in  in  1  raw serial line; idle high.
- data_out  out  DATA_BITS  received byte.
- data_valid  out  1  data_out holds an unconsumed byte.
- data_ready  in  1  consumer accepts; transfer occurs when data_valid && data_ready at a rising edge.
- framing_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: good frame dropped because the holding register was full.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert; release is synchronous to clk_100p0):
  - Sync flops = 1; FSM = IDLE; counters = 0.
  - data_out = 0; data_valid = 0; framing_err = 0; overrun = 0; busy = 0.
- rx_s: the output of the SYNC_STAGES flop chain. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2, integer floor. The baud counter is $clog2(CLKS_PER_BIT) bits wide. The bit index is $clog2(DATA_BITS+1) bits wide.
- FSM states and transitions:
  - IDLE: when rx_s == 0, load baud counter with HALF-1 and go to START.
  - START: count down. At 0, if rx_s == 0, load CLKS_PER_BIT-1, clear bit index and go to DATA. If rx_s == 1, treat as a glitch and return to IDLE with no flags.
  - DATA: count down. At 0, shift rx_s into the MSB of the shift register (LSB-first framing) and reload CLKS_PER_BIT-1. After DATA_BITS samples, go to STOP.
  - STOP: count down. At 0, sample rx_s:
    - rx_s == 1 (good frame): deliver the byte (see holding rule) and go to IDLE in the same cycle, so a start bit beginning half a bit later is caught.
    - rx_s == 0: pulse framing_err, discard the byte, go to RECOVER.
  - RECOVER: wait for rx_s == 1, then go to IDLE. This covers break conditions: a held-low line gives exactly one framing_err, not repeated frames.
- Holding rule at good-stop:
  - If !data_valid, or data_valid && data_ready in the same cycle: load data_out and set data_valid = 1 on the next edge.
  - Otherwise: keep the old byte, data_valid stays 1, pulse overrun. The new byte is lost.
- data_valid clears on the cycle after the handshake unless a reload happens in the same cycle.
- data_out is stable while data_valid = 1 and !data_ready.
- Latency:
  - Let E be the first edge at which the raw pin is registered low into sync stage 1.
  - data_valid rises at edge E + SYNC_STAGES + HALF + (DATA_BITS+1)*CLKS_PER_BIT.
  - CLKS_PER_BIT=16, SYNC_STAGES=2, DATA_BITS=8 gives E+154.
- busy: high in START, DATA, STOP and RECOVER.
- Reset mid-frame: abandon immediately with all outputs at reset values. A frame in flight is lost; the next falling edge after reset release starts a new frame.
- Baud tolerance: mid-bit sampling tolerates about ±4% combined clock mismatch over the frame. No majority vote.

Decomposition:
- Package uart_pkg:
  - rx_state_t enum (IDLE, START, DATA, STOP, RECOVER).
  - Default CLKS_PER_BIT and DATA_BITS constants, shared with the transmitter so both ends cannot drift.
- Sub-module sync_ff: parameterised-depth synchroniser with a reset value parameter (1 here). Reusable for other pin inputs.

Test Plan:
All scenarios use CLKS_PER_BIT=16, SYNC_STAGES=2, DATA_BITS=8.
- Byte 0xA5, data_ready held 1 -> data_out=0xA5, data_valid high exactly 1 cycle at E+154; no flags.
- Back-to-back 0x00 then 0xFF, second start immediately after stop, ready=1 -> two valid beats, 0x00 then 0xFF, no framing_err.
- Glitch: rx_in low for 5 cycles, then high -> no data_valid, no flags; busy high during START, then low.
- Stop bit forced 0 on byte 0x3C, line then held low for 40 cycles -> exactly one framing_err pulse, no data_valid; busy low only after the line returns high.
- ready=0, send 0x11 then 0x22 -> data_valid stays 1 with data_out=0x11; one overrun pulse at the second stop. Raising ready yields 0x11 only.
- rst asserted mid-DATA of byte 0x5A, released, then 0x77 sent -> all outputs 0 during reset; only 0x77 is delivered.
